mem_arbiter_pipe: RTL and testbench
===================================

Name: mem_arbiter_pipe

Overview:
- N-port arbiter in front of one single-port, fixed-latency memory.
- Each requester (instruction fetch, data LW/SW, DMA, debug, ...) issues read/write requests through a req/gnt handshake.
- At most one request is granted per cycle; read data returns on a shared bus exactly LATENCY cycles after the grant, qualified by a per-port rvalid.
- Replaces the two-port ifetch/data front end; sits between the CPU pipeline/peripherals and the memory core.

Parameters:
- ASIZE, 16, address width.
- DSIZE, 16, data width.
- LATENCY, 3, memory read latency in cycles, grant to data; legal range 1..8.
- NPORTS, 2, number of requesters; legal range 1..8; port 0 has the highest fixed priority.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req  in  NPORTS  per-port request; held high until granted.
- wr  in  NPORTS  per-port write qualifier (1 = write, 0 = read); valid with req.
- addr  in  NPORTS*ASIZE  flattened per-port address; port k occupies bits [k*ASIZE +: ASIZE].
- wdata  in  NPORTS*DSIZE  flattened per-port write data.
- gnt  out  NPORTS  one-hot grant, combinational in the same cycle as req.
- rvalid  out  NPORTS  one-hot; high for 1 cycle when rdata belongs to that port.
- rdata  out  DSIZE  shared read data; 0 when no rvalid is high.
- busy  out  1  high while any read is in flight.
- mem_addr  out  ASIZE  memory address; 0 when idle.
- mem_wen  out  1  memory write enable, active-low; 1 when idle.
- mem_din  out  DSIZE  memory write data; wdata of the granted port, 0 when idle.
- mem_dout  in  DSIZE  memory read data, valid LATENCY cycles after its address.

Behaviour:
- Reset (rst high at a clock edge):
  - Response pipeline is cleared; RR pointer (if built) goes to 0.
  - gnt is forced to 0 while rst is high.
  - rvalid=0, rdata=0, busy=0, mem_wen=1, mem_addr=0, mem_din=0.
  - In-flight reads are discarded with no rvalid, even when reset hits mid-operation.
- Arbitration (combinational):
  - Fixed priority: lowest-indexed asserted req wins.
  - gnt[k]=1 only when req[k]=1.
  - Exactly one bit set when any req is high; gnt=0 when req=0.
- Issue (same cycle as gnt):
  - mem_addr = addr of the winner.
  - mem_wen = ~wr of the winner.
  - mem_din = wdata of the winner.
- Writes:
  - Complete at the clock edge where gnt is high.
  - Produce no response and no pipeline entry.
- Reads:
  - Push {valid=1, port id} into a LATENCY-deep shift register at the granted edge.
  - When the entry reaches the stage LATENCY-1 output, rvalid[id]=1 and rdata=mem_dout for that cycle.
  - Total latency: read granted in cycle T gives rvalid in cycle T+LATENCY.
- Throughput:
  - One grant per cycle, fully pipelined, back-to-back reads from any mix of ports.
  - A read may issue in the same cycle an older read returns.
- Ordering: responses return strictly in grant order.
- Read-after-write to the same address in consecutive cycles returns the newly written data; the memory core provides write-before-read across cycles.
- Losing requester: holds req, addr, wr and wdata stable until granted. Dropping req before gnt is permitted and has no effect.
- busy = OR of all pipeline valid bits.
- Width rules:
  - The port id field is max(1, clog2(NPORTS)) bits wide.
  - Flattened buses are indexed with part-selects, never by concatenation order.
- NPORTS=1: arbiter reduces to gnt=req; behaviour is otherwise identical.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - Search starts at pointer p and wraps modulo NPORTS.
  - After any grant to port k, p <= (k+1) mod NPORTS.
  - p is unchanged on idle cycles.
  - A continuously requesting port is granted at least once every NPORTS cycles.
- Undefined: fixed priority as above; no pointer register is built.

Decomposition:
- Package mem_arb_pkg:
  - id width function (clog2, minimum 1).
  - IDLE_ADDR=0, IDLE_WEN=1'b1 constants.
  - Response-entry typedef {valid, id}.
- Sub-module mem_resp_pipe: parametrised LATENCY-deep valid/id shift register with synchronous clear; outputs the head entry and busy.
- Arbiter logic (fixed or RR) stays in the top module.

Test Plan:
- Reset mid-flight: grant a read on port 1 at T, assert rst at T+1 → no rvalid at T+3; busy=0 and mem_wen=1 after reset.
- Single read: LATENCY=3, port 0 read addr 0x0010 (memory holds 0xBEEF) at cycle T → rvalid=2'b01, rdata=0xBEEF at T+3; rdata=0 at T+2 and T+4.
- Write then read: port 1 writes 0x1234 to 0x0020, then reads 0x0020 next cycle → rvalid[1] with rdata=0x1234 three cycles after the read grant; no rvalid for the write.
- Contention, fixed priority: ports 0 and 1 request every cycle for 4 cycles → gnt=01 on all 4; port 1 granted only after port 0 drops req.
- Contention, MEM_ARB_RR_EN, NPORTS=4: all ports request continuously → gnt sequence 0001, 0010, 0100, 1000, 0001; responses return in the same order.
- Back-to-back throughput: 8 consecutive reads alternating ports 0/1 to addresses 0..7 → 8 consecutive rvalid cycles starting at LATENCY, correct port and data each cycle, busy high throughout.

Source files
------------

// File: rtl/mem_arbiter_pipe_pkg.sv
// Shared constants and helpers for the memory arbiter front end.
package mem_arb_pkg;

    // Memory port values driven when no request is granted
    localparam int   IDLE_ADDR = 0;
    localparam logic IDLE_WEN  = 1'b1;

    // Width of a port id: clog2 of the port count, never less than one bit
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_pipe_resp.sv
// Read-response tracker: a LATENCY-deep shift register of {valid, port id}
// entries. The head entry lines up with mem_dout for the read it describes.
module mem_resp_pipe #(
    parameter int LATENCY = 3,
    parameter int IDW     = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push_i,
    input  logic [IDW-1:0] id_i,
    output logic           head_vld_o,
    output logic [IDW-1:0] head_id_o,
    output logic           busy_o
);
    // One entry per cycle of memory latency; the id width follows the port count
    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } resp_entry_t;

    resp_entry_t [LATENCY-1:0] pipe_q;

    // Shift every cycle; a synchronous clear drops all in-flight reads
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= '{valid: push_i, id: id_i};
            for (int s = 1; s < LATENCY; s++)
                pipe_q[s] <= pipe_q[s-1];
        end
    end

    assign head_vld_o = pipe_q[LATENCY-1].valid;
    assign head_id_o  = pipe_q[LATENCY-1].id;

    // Any valid entry means a read is still in flight
    always_comb begin
        busy_o = 1'b0;
        for (int s = 0; s < LATENCY; s++)
            busy_o = busy_o | pipe_q[s].valid;
    end

endmodule

// File: rtl/mem_arbiter_pipe.sv
// N-port arbiter in front of a single-port fixed-latency memory.
// One grant per cycle, reads return in grant order after LATENCY cycles.
// Build option MEM_ARB_RR_EN: round-robin arbitration instead of fixed
// priority (port 0 highest).
module mem_arbiter_pipe
    import mem_arb_pkg::*;
#(
    parameter int ASIZE   = 16,
    parameter int DSIZE   = 16,
    parameter int LATENCY = 3,
    parameter int NPORTS  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NPORTS-1:0]       req,
    input  logic [NPORTS-1:0]       wr,
    input  logic [NPORTS*ASIZE-1:0] addr,
    input  logic [NPORTS*DSIZE-1:0] wdata,
    output logic [NPORTS-1:0]       gnt,
    output logic [NPORTS-1:0]       rvalid,
    output logic [DSIZE-1:0]        rdata,
    output logic                    busy,
    output logic [ASIZE-1:0]        mem_addr,
    output logic                    mem_wen,
    output logic [DSIZE-1:0]        mem_din,
    input  logic [DSIZE-1:0]        mem_dout
);
    localparam int IDW = id_w(NPORTS);

    logic           any_req;
    logic [IDW-1:0] win_id;
    logic           rd_push;
    logic           head_vld;
    logic [IDW-1:0] head_id;

`ifdef MEM_ARB_RR_EN
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;

    // Round-robin winner: first asserted req searching upward from ptr_q, wrapping
    always_comb begin
        int idx;
        idx     = 0;
        any_req = 1'b0;
        win_id  = '0;
        for (int i = 0; i < NPORTS; i++) begin
            idx = (int'(ptr_q) + i) % NPORTS;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                win_id  = IDW'(idx);
            end
        end
        if (rst)
            any_req = 1'b0;
    end

    // Next pointer is the port after the winner, modulo NPORTS
    always_comb begin
        ptr_d = (int'(win_id) == NPORTS - 1) ? '0 : win_id + 1'b1;
    end

    // Pointer advances only on a grant; idle cycles leave it alone
    always_ff @(posedge clk) begin
        if (rst)
            ptr_q <= '0;
        else if (any_req)
            ptr_q <= ptr_d;
    end
`else
    // Fixed priority winner: scan downward so the lowest asserted index is kept
    always_comb begin
        any_req = 1'b0;
        win_id  = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                any_req = 1'b1;
                win_id  = IDW'(i);
            end
        end
        if (rst)
            any_req = 1'b0;
    end
`endif

    // One-hot grant and memory issue mux, idle values when nothing is granted
    always_comb begin
        gnt      = '0;
        mem_addr = ASIZE'(IDLE_ADDR);
        mem_wen  = IDLE_WEN;
        mem_din  = '0;
        rd_push  = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            if (any_req && win_id == IDW'(k)) begin
                gnt[k]   = 1'b1;
                mem_addr = addr[k*ASIZE +: ASIZE];
                mem_wen  = ~wr[k];
                mem_din  = wdata[k*DSIZE +: DSIZE];
                rd_push  = ~wr[k];
            end
        end
    end

    mem_resp_pipe #(
        .LATENCY (LATENCY),
        .IDW     (IDW)
    ) u_resp_pipe (
        .clk        (clk),
        .rst        (rst),
        .push_i     (rd_push),
        .id_i       (win_id),
        .head_vld_o (head_vld),
        .head_id_o  (head_id),
        .busy_o     (busy)
    );

    // Steer the returning memory data to the owning port; zero otherwise
    always_comb begin
        rvalid = '0;
        rdata  = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (head_vld && head_id == IDW'(k)) begin
                rvalid[k] = 1'b1;
                rdata     = mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_pipe.sv
// Directed bench for mem_arbiter_pipe with a 3-cycle behavioural memory.
module tb_mem_arbiter_pipe;
`ifdef MEM_ARB_RR_EN
    localparam int NP = 4;
`else
    localparam int NP = 2;
`endif
    localparam int AW = 16;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    req, wr, gnt, rvalid;
    logic [NP*AW-1:0] addr;
    logic [NP*DW-1:0] wdata;
    logic [DW-1:0]    rdata, mem_din, mem_dout;
    logic [AW-1:0]    mem_addr;
    logic             mem_wen, busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [65536];
    logic [DW-1:0] dpipe [3];

    mem_arbiter_pipe #(.ASIZE(AW), .DSIZE(DW), .LATENCY(3), .NPORTS(NP)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Memory core: contents reload on reset, writes land at the edge, reads take 3 cycles
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 16'hA000 + 16'(i);
            mem[16'h0010] <= 16'hBEEF;
        end else if (!mem_wen) begin
            mem[mem_addr] <= mem_din;
        end
        dpipe[0] <= mem[mem_addr];
        dpipe[1] <= dpipe[0];
        dpipe[2] <= dpipe[1];
    end
    assign mem_dout = dpipe[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = '0;
        wr  = '0;
    endtask

    task automatic set_port(input int k, input logic w, input logic [15:0] a, input logic [15:0] d);
        req[k] = 1'b1;
        wr[k]  = w;
        addr[k*AW +: AW]  = a;
        wdata[k*DW +: DW] = d;
    endtask

    initial begin
        rst = 1'b1; req = '0; wr = '0; addr = '0; wdata = '0;

        // Reset state, grants suppressed even with requests present
        cyc(); cyc();
        req = '1;
        #3;
        check("rst_gnt",    32'(gnt),      32'h0);
        check("rst_wen",    32'(mem_wen),  32'h1);
        check("rst_addr",   32'(mem_addr), 32'h0);
        check("rst_din",    32'(mem_din),  32'h0);
        check("rst_rvalid", 32'(rvalid),   32'h0);
        check("rst_rdata",  32'(rdata),    32'h0);
        check("rst_busy",   32'(busy),     32'h0);
        cyc();
        rst = 1'b0; idle();

        // Single read, port 0, addr 0x0010
        set_port(0, 1'b0, 16'h0010, 16'h0);
        #3;
        check("rd_gnt",   32'(gnt),      32'h1);
        check("rd_addr",  32'(mem_addr), 32'h0010);
        check("rd_wen",   32'(mem_wen),  32'h1);
        check("rd_busy0", 32'(busy),     32'h0);
        cyc(); idle(); #3;
        check("rd_idle_gnt",  32'(gnt),      32'h0);
        check("rd_idle_addr", 32'(mem_addr), 32'h0);
        check("rd_busy1",     32'(busy),     32'h1);
        cyc(); #3;
        check("rd_t2_rvalid", 32'(rvalid), 32'h0);
        check("rd_t2_rdata",  32'(rdata),  32'h0);
        cyc(); #3;
        check("rd_t3_rvalid", 32'(rvalid), 32'h1);
        check("rd_t3_rdata",  32'(rdata),  32'hBEEF);
        cyc(); #3;
        check("rd_t4_rdata",  32'(rdata),  32'h0);
        check("rd_t4_busy",   32'(busy),   32'h0);

        // Write then read-back on port 1
        cyc(); idle();
        set_port(1, 1'b1, 16'h0020, 16'h1234);
        #3;
        check("wr_gnt",  32'(gnt),      32'h2);
        check("wr_wen",  32'(mem_wen),  32'h0);
        check("wr_addr", 32'(mem_addr), 32'h0020);
        check("wr_din",  32'(mem_din),  32'h1234);
        cyc(); idle();
        set_port(1, 1'b0, 16'h0020, 16'h0);
        #3;
        check("raw_gnt", 32'(gnt),     32'h2);
        check("raw_wen", 32'(mem_wen), 32'h1);
        check("raw_din", 32'(mem_din), 32'h0);
        cyc(); idle(); #3;
        cyc(); #3;
        check("wr_no_resp", 32'(rvalid), 32'h0);
        cyc(); #3;
        check("raw_rvalid", 32'(rvalid), 32'h2);
        check("raw_rdata",  32'(rdata),  32'h1234);

        // Back-to-back reads alternating ports 0/1, addresses 0..7
        for (int i = 0; i < 12; i++) begin
            cyc(); idle();
            if (i < 8) set_port(i % 2, 1'b0, 16'(i), 16'h0);
            #3;
            if (i < 8) check("b2b_gnt", 32'(gnt), 32'(1 << (i % 2)));
            if (i >= 3 && i < 11) begin
                check("b2b_rvalid", 32'(rvalid), 32'(1 << ((i - 3) % 2)));
                check("b2b_rdata",  32'(rdata),  32'h0000A000 + 32'(i - 3));
            end
            if (i >= 1 && i <= 10) check("b2b_busy", 32'(busy), 32'h1);
            if (i == 11) check("b2b_drain", 32'(busy), 32'h0);
        end

        // Reset one cycle after a read grant discards the read
        cyc(); idle();
        set_port(1, 1'b0, 16'h0005, 16'h0);
        #3;
        check("mid_gnt", 32'(gnt), 32'h2);
        cyc(); idle(); rst = 1'b1; #3;
        cyc(); rst = 1'b0; #3;
        check("mid_busy",   32'(busy),    32'h0);
        check("mid_wen",    32'(mem_wen), 32'h1);
        check("mid_rvalid", 32'(rvalid),  32'h0);
        cyc(); #3;
        check("mid_t3_rvalid", 32'(rvalid), 32'h0);
        check("mid_t3_rdata",  32'(rdata),  32'h0);

`ifdef MEM_ARB_RR_EN
        // All four ports request continuously: rotating grants, responses in grant order
        for (int i = 0; i < 8; i++) begin
            cyc(); idle();
            if (i < 5) for (int k = 0; k < NP; k++) set_port(k, 1'b0, 16'h0030 + 16'(k), 16'h0);
            #3;
            if (i < 5) check("rr_gnt", 32'(gnt), 32'(1 << (i % 4)));
            if (i >= 3) begin
                check("rr_rvalid", 32'(rvalid), 32'(1 << ((i - 3) % 4)));
                check("rr_rdata",  32'(rdata),  32'h0000A030 + 32'((i - 3) % 4));
            end
        end
`else
        // Ports 0 and 1 both request: port 0 wins until it drops
        for (int i = 0; i < 9; i++) begin
            cyc(); idle();
            if (i < 4) begin
                set_port(0, 1'b0, 16'h0001, 16'h0);
                set_port(1, 1'b0, 16'h0002, 16'h0);
            end else if (i == 4) begin
                set_port(1, 1'b0, 16'h0002, 16'h0);
            end
            #3;
            if (i < 4)  check("fp_gnt0", 32'(gnt), 32'h1);
            if (i == 4) check("fp_gnt1", 32'(gnt), 32'h2);
            if (i >= 3 && i <= 6) begin
                check("fp_rvalid0", 32'(rvalid), 32'h1);
                check("fp_rdata0",  32'(rdata),  32'hA001);
            end
            if (i == 7) begin
                check("fp_rvalid1", 32'(rvalid), 32'h2);
                check("fp_rdata1",  32'(rdata),  32'hA002);
            end
            if (i == 8) check("fp_drain", 32'(busy), 32'h0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
